// File: rtl/lfsr_rx_checker.sv
// PRBS receive checker: self-synchronises to an LFSR sequence on parallel RX words,
// locks after a clean run and then counts bit errors, checked words and lock losses.
module lfsr_rx_checker #(
  parameter int DATA_W     = 32,
  parameter int LFSR_W     = 31,
  parameter int TAP        = 28,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_bit_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [15:0]       lock_loss_cnt
);

  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int POP_W   = $clog2(DATA_W + 1);
  localparam int EXT_W   = LFSR_W + DATA_W;
  localparam int SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [LFSR_W-1:0]   lfsr, lfsr_nxt;
  logic [RUN_W-1:0]    run, run_nxt;
  logic [DATA_W-1:0]   exp_word, diff;
  logic [POP_W-1:0]    err_bits;
  logic                pulse_nxt;
  logic [CNT_W-1:0]    err_cnt_nxt, word_cnt_nxt;
  logic [15:0]         loss_nxt;

  // Extends the state by DATA_W bits; bit k of the extended vector is later in
  // time than bit k+1, so s[n-L] sits L positions above s[n].
  function automatic logic [DATA_W-1:0] predict(input logic [LFSR_W-1:0] s);
    logic [EXT_W-1:0] e;
    e = {s, {DATA_W{1'b0}}};
    for (int k = DATA_W - 1; k >= 0; k--)
      e[k] = e[k + LFSR_W] ^ e[k + TAP];
    return e[DATA_W-1:0];
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++)
      c = c + {{(POP_W-1){1'b0}}, v[i]};
    return c;
  endfunction

  // Saturates when the true sum would exceed the counter range, not only at max.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'({CNT_W{1'b1}}))
      return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  assign exp_word = predict(lfsr);
  assign diff     = din ^ exp_word;
  assign err_bits = popcount(diff);
  assign locked   = (state == LOCKED);

  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    run_nxt      = run;
    pulse_nxt    = 1'b0;
    err_cnt_nxt  = err_bit_cnt;
    word_cnt_nxt = word_cnt;
    loss_nxt     = lock_loss_cnt;
    if (din_vld) begin
      unique case (state)
        SEARCH: begin
          if (din[LFSR_W-1:0] != '0) begin
            lfsr_nxt  = din[LFSR_W-1:0];
            run_nxt   = '0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (diff == '0) begin
            lfsr_nxt = exp_word[LFSR_W-1:0];
            run_nxt  = run + RUN_W'(1);
            if (run_nxt == RUN_W'(LOCK_CNT)) begin
              run_nxt   = '0;
              state_nxt = LOCKED;
            end
          end else begin
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          // Advance from prediction only, so a bad word never corrupts the state.
          lfsr_nxt     = exp_word[LFSR_W-1:0];
          word_cnt_nxt = sat_add(word_cnt, POP_W'(1));
          err_cnt_nxt  = sat_add(err_bit_cnt, err_bits);
          pulse_nxt    = (err_bits != '0);
          if (err_bits != '0) begin
            run_nxt = run + RUN_W'(1);
            if (run_nxt == RUN_W'(UNLOCK_CNT)) begin
              run_nxt   = '0;
              state_nxt = SEARCH;
              loss_nxt  = sat_inc16(lock_loss_cnt);
            end
          end else begin
            run_nxt = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
    if (clr) begin
      err_cnt_nxt  = '0;
      word_cnt_nxt = '0;
      loss_nxt     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEARCH;
      lfsr          <= '0;
      run           <= '0;
      err_pulse     <= 1'b0;
      err_bit_cnt   <= '0;
      word_cnt      <= '0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_nxt;
      lfsr          <= lfsr_nxt;
      run           <= run_nxt;
      err_pulse     <= pulse_nxt;
      err_bit_cnt   <= err_cnt_nxt;
      word_cnt      <= word_cnt_nxt;
      lock_loss_cnt <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_rx_checker.sv
// Directed bench for lfsr_rx_checker: a 32-bit-counter instance and a 4-bit-counter
// instance share stimulus generated by a bit-serial PRBS31 reference.
module tb_lfsr_rx_checker;

  logic        clk = 1'b0;
  logic        rst, clr, din_vld;
  logic [31:0] din;

  logic        locked, err_pulse;
  logic [31:0] err_bit_cnt, word_cnt;
  logic [15:0] lock_loss_cnt;

  logic        locked4, err_pulse4;
  logic [3:0]  err_bit_cnt4, word_cnt4;
  logic [15:0] lock_loss_cnt4;

  lfsr_rx_checker #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_vld(din_vld),
    .locked(locked), .err_pulse(err_pulse), .err_bit_cnt(err_bit_cnt),
    .word_cnt(word_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  lfsr_rx_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_vld(din_vld),
    .locked(locked4), .err_pulse(err_pulse4), .err_bit_cnt(err_bit_cnt4),
    .word_cnt(word_cnt4), .lock_loss_cnt(lock_loss_cnt4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [30:0] h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  // Serial PRBS31 reference: s[n] = s[n-31] ^ s[n-28], MSB of each word first.
  task automatic next_word(output logic [31:0] w);
    logic nb;
    for (int i = 31; i >= 0; i--) begin
      nb = h[30] ^ h[27];
      h  = {h[29:0], nb};
      w[i] = nb;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic v);
    din     = d;
    din_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean();
    logic [31:0] w;
    next_word(w);
    send(w, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    logic        seen;
    int          sum;

    rst = 1'b1; clr = 1'b0; din_vld = 1'b0; din = '0;
    h = 31'h7FFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_errcnt", err_bit_cnt, 0);
    chk("rst_wordcnt", word_cnt, 0);
    chk("rst_losscnt", lock_loss_cnt, 0);
    rst = 1'b0;

    seen = 1'b0;
    repeat (40) begin
      send(32'h0, 1'b1);
      seen |= locked;
    end
    chk("zero_search_nolock", seen, 0);

    for (int i = 0; i <= 16; i++) begin
      send_clean();
      if (i == 15) chk("s1_prelock", locked, 0);
    end
    chk("s1_lock", locked, 1);
    chk("s1_wc0", word_cnt, 0);
    seen = 1'b0;
    repeat (100) begin
      send_clean();
      seen |= err_pulse;
    end
    chk("s1_wc100", word_cnt, 100);
    chk("s1_err0", err_bit_cnt, 0);
    chk("s1_nopulse", seen, 0);
    chk("s1_wc4_sat", word_cnt4, 15);

    next_word(w);
    send(w ^ 32'h00000105, 1'b1);
    chk("s2_pulse", err_pulse, 1);
    chk("s2_err3", err_bit_cnt, 3);
    chk("s2_locked", locked, 1);
    send_clean();
    chk("s2_pulse_off", err_pulse, 0);
    chk("s2_noprop", err_bit_cnt, 3);
    chk("s2_wc", word_cnt, 102);

    sum = 0;
    for (int i = 0; i < 4; i++) begin
      next_word(w);
      sum += $countones(w);
      send(32'h0, 1'b1);
      if (i == 2) chk("s3_still_locked", locked, 1);
    end
    chk("s3_unlock", locked, 0);
    chk("s3_loss", lock_loss_cnt, 1);
    chk("s3_err", err_bit_cnt, 32'(3 + sum));
    chk("s3_wc", word_cnt, 106);
    for (int i = 0; i <= 16; i++) begin
      send_clean();
      if (i == 15) chk("s3_prerelock", locked, 0);
    end
    chk("s3_relock", locked, 1);

    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c % 2 == 1) send(32'hDEADBEEF, 1'b0);
      else send_clean();
      if (c == 33) chk("s4_prelock", locked, 0);
    end
    chk("s4_lock34", locked, 1);
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c % 2 == 1) send(32'hDEADBEEF, 1'b0);
      else send_clean();
      seen |= err_pulse;
      if (c == 19) chk("s4_wc9", word_cnt, 9);
    end
    chk("s4_wc10", word_cnt, 10);
    chk("s4_nopulse", seen, 0);

    clr = 1'b1;
    send_clean();
    clr = 1'b0;
    chk("s5_clr_err4", err_bit_cnt4, 0);
    chk("s5_clr_wc4", word_cnt4, 0);
    for (int i = 0; i < 14; i++) begin
      next_word(w);
      send(w ^ 32'h1, 1'b1);
      send_clean();
    end
    chk("s5_err4_14", err_bit_cnt4, 14);
    chk("s5_wc4_sat", word_cnt4, 15);
    next_word(w);
    send(w ^ 32'h00000105, 1'b1);
    chk("s5_err4_ovf", err_bit_cnt4, 15);
    chk("s5_err32_17", err_bit_cnt, 17);
    next_word(w);
    send(w ^ 32'h1, 1'b1);
    chk("s5_err4_hold", err_bit_cnt4, 15);
    chk("s5_err32_18", err_bit_cnt, 18);
    send_clean();
    clr = 1'b1;
    next_word(w);
    send(w ^ 32'h1, 1'b1);
    clr = 1'b0;
    chk("s5_clrpri_err4", err_bit_cnt4, 0);
    chk("s5_clrpri_pulse4", err_pulse4, 1);
    chk("s5_clrpri_err32", err_bit_cnt, 0);
    chk("s5_clr_keeplock", locked, 1);

    next_word(w);
    send(w ^ 32'h3, 1'b1);
    chk("s6_pre_pulse", err_pulse, 1);
    chk("s6_pre_wc", word_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async_locked", locked, 0);
    chk("s6_async_pulse", err_pulse, 0);
    chk("s6_async_err", err_bit_cnt, 0);
    chk("s6_async_wc", word_cnt, 0);
    chk("s6_async_loss", lock_loss_cnt, 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      send_clean();
      if (i == 15) chk("s6_prelock", locked, 0);
    end
    chk("s6_relock", locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rx_checker.md
Name: lfsr_rx_checker

Overview:
- Receive-side checker for the PRBS31 LFSR pattern that the SFP0 GTH path transmits; it is the companion to that transmitter.
- Sits on the GTH RX user-clock domain and consumes parallel RX words.
- Self-synchronises to the incoming sequence, declares lock, then counts bit errors, checked words and lock losses for software readout.
- Used to qualify the optical link without the classical NIC attached.

Parameters:
- DATA_W, 32: parallel word width; must be >= LFSR_W.
- LFSR_W, 31: LFSR length (sequence order).
- TAP, 28: second feedback tap. Recurrence is s[n] = s[n-LFSR_W] ^ s[n-TAP].
- LOCK_CNT, 16: consecutive matching words in VERIFY required to lock.
- UNLOCK_CNT, 4: consecutive errored words in LOCKED that drop lock.
- CNT_W, 32: width of the error and word counters.

Ports:
- clk, in, 1: RX word clock. This is the block's only clock.
- rst, in, 1: asynchronous, active-high reset.
- clr, in, 1: synchronous clear of all counters; does not affect lock state.
- din, in, DATA_W: received word. din[DATA_W-1] is the earliest bit in time.
- din_vld, in, 1: din is valid this cycle.
- locked, out, 1: checker is in LOCKED.
- err_pulse, out, 1: one-cycle strobe, set when a checked word had at least one bit error.
- err_bit_cnt, out, CNT_W: saturating count of errored bits while locked.
- word_cnt, out, CNT_W: saturating count of words checked while locked.
- lock_loss_cnt, out, 16: saturating count of LOCKED->SEARCH transitions.

Behaviour:
- Reset (async assert, release sampled on clk):
  - State is SEARCH.
  - Outputs: locked=0, err_pulse=0, all counters=0.
  - LFSR state=0, run counters=0.
- LFSR state register is LFSR_W bits.
- Predicted word:
  - Combinationally extend the state by DATA_W bits via the recurrence, giving exp[DATA_W-1:0] in the same bit order as din.
  - The next state is the last LFSR_W bits of the extended sequence.
- The state machine only advances on cycles with din_vld=1. With din_vld=0 all state holds and err_pulse=0.
- SEARCH:
  - On a valid word, seed = din[LFSR_W-1:0].
  - If seed is all zero, stay in SEARCH (a zero seed is a degenerate lock).
  - Otherwise load the state with the seed, clear the good-run counter and go to VERIFY.
- VERIFY:
  - Compare din with exp.
  - Match: advance the state and increment the good-run counter. When the counter reaches LOCK_CNT, go to LOCKED.
  - Mismatch: go to SEARCH and reseed from the next valid word, not from the mismatching one.
  - No counters are updated in VERIFY.
- LOCKED:
  - Compare din with exp; e = popcount(din ^ exp).
  - The state always advances from predicted bits, never from din, so errors do not propagate.
  - word_cnt += 1 on every valid word.
  - err_bit_cnt += e.
  - err_pulse = (e != 0).
  - The bad-run counter increments on e != 0 and clears on e == 0.
  - When the bad run reaches UNLOCK_CNT: go to SEARCH, lock_loss_cnt += 1, locked deasserts.
- Latency: every output is registered and updates in the cycle after the clk edge that samples the valid word.
- With clean input:
  - Word 0 seeds the LFSR.
  - Words 1..LOCK_CNT verify.
  - locked=1 is visible the cycle after word LOCK_CNT is sampled.
  - The first word counted in word_cnt is word LOCK_CNT+1.
- Saturation:
  - err_bit_cnt and word_cnt stick at 2^CNT_W-1 and never wrap.
  - err_bit_cnt saturates when the sum would overflow, not just when it is already at maximum.
  - lock_loss_cnt sticks at 0xFFFF.
- clr:
  - All three counters go to 0 at the next edge.
  - clr has priority over a simultaneous increment; the count is 0, not 0 + e.
  - err_pulse still reflects that cycle's word.
- rst mid-operation: immediate async return to reset values. No counter is preserved.

Test Plan:
1. Clean PRBS31 from seed 0x7FFFFFFF, din_vld=1 continuously, DATA_W=32 -> locked=1 the cycle after word 16 is sampled. After 100 further words: word_cnt=100, err_bit_cnt=0, err_pulse never high.
2. While locked, XOR 0x00000105 into one word -> err_pulse high for exactly 1 cycle. err_bit_cnt increases by 3, locked stays 1. The next clean word produces no error, showing no propagation.
3. While locked, drive 4 consecutive din=0 words -> locked drops the cycle after the 4th, lock_loss_cnt=1, err_bit_cnt increases by the popcounts of those exp words. Then resume clean PRBS -> relock after 17 valid words. Also: all-zero input in SEARCH keeps locked=0 indefinitely.
4. din_vld toggling 1/0 every cycle with clean data -> lock reached after 17 valid words (34 cycles). word_cnt increments only on valid cycles. err_pulse=0.
5. CNT_W=4: inject 1-bit errors while locked until the count passes 15 -> err_bit_cnt holds at 15. Then clr together with an errored word -> err_bit_cnt=0 and err_pulse=1 that cycle.
6. Assert rst asynchronously mid-LOCKED, between clock edges -> locked, err_pulse and all counters go to 0 without waiting for a clk edge. After release, a clean stream relocks per scenario 1 timing.
